controller_reader_m: RTL and testbench

Polls both NES-style serial game controllers and holds the latest button bytes for the CPU at the IO addresses 0x7002 (controller 1) and 0x7003 (controller 2). It sits behind the address bus decoder and is driven by its `SELECT_controller_1` and `SELECT_controller_2` strobes. A poll is triggered by a one-cycle `start` pulse; the video block issues it at the start of vblank. The block generates the controller latch and clock waveforms, shifts in both data lines in parallel, and commits both bytes atomically.

---
 rtl/controller_reader_pkg.sv | 31 +++
 rtl/controller_sync_m.sv | 24 ++
 rtl/controller_reader_m.sv | 139 +++++++++++++
 tb/tb_controller_reader_m.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_reader_pkg.sv
// Shared definitions for the NES controller reader: FSM states, button bit positions
// and the CPU IO addresses decoded for the two controller ports.
package controller_reader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLatch = 2'd1,
        StLow   = 2'd2,
        StHigh  = 2'd3
    } reader_state_e;

    localparam int unsigned NumButtons = 8;

    localparam int unsigned BtnA      = 7;
    localparam int unsigned BtnB      = 6;
    localparam int unsigned BtnSelect = 5;
    localparam int unsigned BtnStart  = 4;
    localparam int unsigned BtnUp     = 3;
    localparam int unsigned BtnDown   = 2;
    localparam int unsigned BtnLeft   = 1;
    localparam int unsigned BtnRight  = 0;

    localparam logic [15:0] AddrController1 = 16'h7002;
    localparam logic [15:0] AddrController2 = 16'h7003;

    // Pins are active-low; a pressed button is stored as 1, first bit lands in the MSB.
    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic pin_n);
        return {sr[6:0], ~pin_n};
    endfunction

endpackage

// File: rtl/controller_sync_m.sv
// Two-flop synchronizer for one controller data line; resets to the idle-high level.
module controller_sync_m (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/controller_reader_m.sv
// Polls two NES serial controllers and holds the latest button bytes for CPU reads.
// Define CONTROLLER_READER_SYNC_EN to pass the data pins through two-flop synchronizers.
module controller_reader_m
    import controller_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       SELECT_controller_1,
    input  logic       SELECT_controller_2,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       ctrl_latch,
    output logic       ctrl_clk,
    input  logic       ctrl_data_1,
    input  logic       ctrl_data_2
);

    localparam int unsigned CntW = $clog2(2 * CLK_DIV);
    localparam logic [CntW-1:0] LatchLast = CntW'(2 * CLK_DIV - 1);
    localparam logic [CntW-1:0] PhaseLast = CntW'(CLK_DIV - 1);

    logic w_data_1;
    logic w_data_2;

`ifdef CONTROLLER_READER_SYNC_EN
    // Synchronizer latency must stay inside one LOW phase so samples remain aligned.
    if (CLK_DIV < 4) begin : g_clk_div_check
        $error("controller_reader_m: CLK_DIV must be >= 4 with the synchronizer enabled");
    end

    controller_sync_m u_sync_1 (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (ctrl_data_1),
        .o_q  (w_data_1)
    );

    controller_sync_m u_sync_2 (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (ctrl_data_2),
        .o_q  (w_data_2)
    );
`else
    assign w_data_1 = ctrl_data_1;
    assign w_data_2 = ctrl_data_2;
`endif

    reader_state_e   r_state;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift1;
    logic [7:0]      r_shift2;
    logic [7:0]      r_hold1;
    logic [7:0]      r_hold2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift1   <= '0;
            r_shift2   <= '0;
            r_hold1    <= '0;
            r_hold2    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ctrl_latch <= 1'b0;
            ctrl_clk   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state    <= StLatch;
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        busy       <= 1'b1;
                        ctrl_latch <= 1'b1;
                    end
                end
                StLatch: begin
                    if (r_cnt == LatchLast) begin
                        r_state    <= StLow;
                        r_cnt      <= '0;
                        ctrl_latch <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StLow: begin
                    if (r_cnt == PhaseLast) begin
                        r_state  <= StHigh;
                        r_cnt    <= '0;
                        ctrl_clk <= 1'b1;
                        r_shift1 <= shift_in(r_shift1, w_data_1);
                        r_shift2 <= shift_in(r_shift2, w_data_2);
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StHigh: begin
                    if (r_cnt == PhaseLast) begin
                        r_cnt    <= '0;
                        ctrl_clk <= 1'b0;
                        if (r_idx == 3'd7) begin
                            // Both bytes commit together so a CPU read never sees a mix.
                            r_state <= StIdle;
                            r_hold1 <= r_shift1;
                            r_hold2 <= r_shift2;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= StLow;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (SELECT_controller_1) begin
            data_out = r_hold1;
        end else if (SELECT_controller_2) begin
            data_out = r_hold2;
        end
    end

endmodule

// File: tb/tb_controller_reader_m.sv
// Self-checking bench for controller_reader_m: behavioural poll model plus directed cases.
module tb_controller_reader_m;

    localparam int D = 4;
    localparam int PollLen = 18 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       sel1 = 1'b0;
    logic       sel2 = 1'b0;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       ctrl_latch;
    logic       ctrl_clk;
    logic       ctrl_data_1;
    logic       ctrl_data_2;

    logic [7:0] btn1 = 8'h00;
    logic [7:0] btn2 = 8'h00;

    int n_checks = 0;
    int n_fail = 0;

    controller_reader_m #(.CLK_DIV(D)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .SELECT_controller_1(sel1),
        .SELECT_controller_2(sel2),
        .data_out           (data_out),
        .busy               (busy),
        .done               (done),
        .ctrl_latch         (ctrl_latch),
        .ctrl_clk           (ctrl_clk),
        .ctrl_data_1        (ctrl_data_1),
        .ctrl_data_2        (ctrl_data_2)
    );

    always #5 clk = ~clk;

    // Controller model: a 4021 shift register loaded by latch, advanced by ctrl_clk rising.
    logic [7:0] c_sr1 = 8'h00;
    logic [7:0] c_sr2 = 8'h00;
    int         c_k = 8;

    always @(posedge ctrl_clk or posedge ctrl_latch) begin
        if (ctrl_latch) begin
            c_sr1 <= btn1;
            c_sr2 <= btn2;
            c_k   <= 0;
        end else begin
            c_k <= c_k + 1;
        end
    end

    function automatic logic pin_level(input logic [7:0] b, input int k);
        if (k < 0 || k > 7) return 1'b1;
        return ~b[7-k];
    endfunction

    assign ctrl_data_1 = pin_level(c_sr1, c_k);
    assign ctrl_data_2 = pin_level(c_sr2, c_k);

    // Reference model: cycles elapsed since the accepted start, -1 when idle.
    int         m_n = -1;
    logic       m_done = 1'b0;
    logic [7:0] m_b1 = 8'h00;
    logic [7:0] m_b2 = 8'h00;
    logic [7:0] m_h1 = 8'h00;
    logic [7:0] m_h2 = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n    <= -1;
            m_done <= 1'b0;
            m_h1   <= 8'h00;
            m_h2   <= 8'h00;
        end else begin
            m_done <= 1'b0;
            if (m_n < 0) begin
                if (start) begin
                    m_n  <= 0;
                    m_b1 <= btn1;
                    m_b2 <= btn2;
                end
            end else if (m_n == PollLen - 1) begin
                m_n    <= -1;
                m_done <= 1'b1;
                m_h1   <= m_b1;
                m_h2   <= m_b2;
            end else begin
                m_n <= m_n + 1;
            end
        end
    end

    function automatic logic exp_latch(input int n);
        return (n >= 0) && (n < 2 * D);
    endfunction

    function automatic logic exp_clk(input int n);
        return (n >= 2 * D) && ((((n - 2 * D) / D) % 2) == 1);
    endfunction

    function automatic logic [7:0] exp_read(input logic s1, input logic s2,
                                            input logic [7:0] h1, input logic [7:0] h2);
        return s1 ? h1 : (s2 ? h2 : 8'h00);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check("busy", {7'd0, busy}, {7'd0, m_n >= 0});
        check("done", {7'd0, done}, {7'd0, m_done});
        check("ctrl_latch", {7'd0, ctrl_latch}, {7'd0, exp_latch(m_n)});
        check("ctrl_clk", {7'd0, ctrl_clk}, {7'd0, exp_clk(m_n)});
        check("data_out", data_out, exp_read(sel1, sel2, m_h1, m_h2));
    end

    // Activity monitors, read by the directed sequences as before/after differences.
    int edge_cnt = 0;
    int lat_cycles = 0;
    int clkhi_cycles = 0;
    int done_cnt = 0;
    int last_done = -1;
    int clk_pulses = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk) begin
        #1;
        lat_cycles   <= lat_cycles + int'(ctrl_latch);
        clkhi_cycles <= clkhi_cycles + int'(ctrl_clk);
        done_cnt     <= done_cnt + int'(done);
        if (done) last_done <= edge_cnt - 1;
    end

    always @(posedge ctrl_clk) clk_pulses <= clk_pulses + 1;

    int e0;

    // Drive start for one edge; returns with time just after that edge (delta 0).
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = edge_cnt - 1;
    endtask

    initial begin
        int s_lat, s_hi, s_pulse, s_done;

        #1 rst_n = 1'b0;
        sel1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy", {7'd0, busy}, 8'h00);
        check("rst latch/clk/done", {5'd0, ctrl_latch, ctrl_clk, done}, 8'h00);
        check("rst read sel1", data_out, 8'h00);
        sel1 = 1'b0;
        sel2 = 1'b1;
        #1 check("rst read sel2", data_out, 8'h00);
        sel2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Poll timing: controller 1 presses A and Right only.
        btn1 = 8'h81;
        btn2 = 8'h00;
        s_lat = lat_cycles; s_hi = clkhi_cycles; s_pulse = clk_pulses; s_done = done_cnt;
        pulse_start();
        repeat (PollLen) @(negedge clk);
        check("poll done at 72", {7'd0, done}, 8'h01);
        check("poll done edge", 8'(last_done - e0), 8'd72);
        check("latch cycles", 8'(lat_cycles - s_lat), 8'd8);
        check("clk high cycles", 8'(clkhi_cycles - s_hi), 8'd32);
        check("clk pulses", 8'(clk_pulses - s_pulse), 8'd8);
        check("done count", 8'(done_cnt - s_done), 8'd1);
        sel1 = 1'b1;
        #1 check("read hold1", data_out, 8'h81);
        sel1 = 1'b0;
        sel2 = 1'b1;
        #1 check("read hold2", data_out, 8'h00);
        sel2 = 1'b0;
        @(negedge clk);

        // Read stability: hold2 = 10, then a poll with every button on controller 2.
        btn2 = 8'h10;
        pulse_start();
        repeat (PollLen + 2) @(negedge clk);
        btn2 = 8'hFF;
        sel2 = 1'b1;
        pulse_start();
        repeat (PollLen - 1) @(negedge clk);
        check("stable read before commit", data_out, 8'h10);
        @(negedge clk);
        check("read after commit", data_out, 8'hFF);
        sel2 = 1'b0;
        @(negedge clk);

        // Start while busy: pulses at 0, 30, 72 give one poll; 73 starts another.
        btn1 = 8'hC3;
        btn2 = 8'h66;
        s_done = done_cnt;
        pulse_start();
        for (int d = 1; d <= 80; d++) begin
            start = (d == 30 || d == 72 || d == 73);
            @(negedge clk);
        end
        start = 1'b0;
        check("busy start done count", 8'(done_cnt - s_done), 8'd1);
        check("busy start done edge", 8'(last_done - e0), 8'd72);
        check("restart at 73 busy", {7'd0, busy}, 8'h01);
        repeat (PollLen) @(negedge clk);

        // Reset at edge 40 of a poll.
        btn1 = 8'h5A;
        s_done = done_cnt;
        pulse_start();
        repeat (39) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid-reset clk/latch", {6'd0, ctrl_clk, ctrl_latch}, 8'h00);
        check("mid-reset busy", {7'd0, busy}, 8'h00);
        sel1 = 1'b1;
        #1 check("mid-reset hold1", data_out, 8'h00);
        sel1 = 1'b0;
        sel2 = 1'b1;
        #1 check("mid-reset hold2", data_out, 8'h00);
        sel2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("aborted poll no done", 8'(done_cnt - s_done), 8'd0);
        btn1 = 8'h3C;
        pulse_start();
        repeat (PollLen) @(negedge clk);
        check("clean poll done edge", 8'(last_done - e0), 8'd72);
        sel1 = 1'b1;
        #1 check("clean poll hold1", data_out, 8'h3C);
        @(negedge clk);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            sel1 = 1'($urandom);
            sel2 = 1'($urandom);
            start = ($urandom_range(0, 19) == 0);
            if (m_n < 0 && start) begin
                btn1 = 8'($urandom);
                btn2 = 8'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (PollLen + 4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
